// File: rtl/soc_pll_lock_supervisor.sv
// soc_pll_lock_supervisor: PLL reset sequencing and lock qualification.
// Optional PLL_SUP_LOSS_CNT_EN adds a saturating lock-loss counter.
module soc_pll_lock_supervisor #(
    parameter int RST_HOLD     = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int STABLE_CNT   = 1024,
    parameter int CW           = 16
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        pll_locked,
    output logic        pll_rst,
    output logic        sys_rst,
    output logic        ready,
    output logic [1:0]  state,
`ifdef PLL_SUP_LOSS_CNT_EN
    output logic [15:0] loss_cnt,
`endif
    output logic [7:0]  retry_cnt
);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } st_t;

    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] ST_LAST   = CW'(STABLE_CNT - 1);

    st_t           state_q;
    st_t           state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          sync1;
    logic          lk;
    logic          retry_inc;
    logic          loss_inc;

    assign state = state_q;

    // Two-flop synchroniser for the asynchronous lock pin
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1 <= 1'b0;
            lk    <= 1'b0;
        end else begin
            sync1 <= pll_locked;
            lk    <= sync1;
        end
    end

    // Next-state and counter logic; lock is tested before timeout
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        unique case (state_q)
            RESET_PLL: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = RESET_PLL;
                    cnt_d     = '0;
                    retry_inc = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == ST_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                if (!lk) begin
                    state_d  = WAIT_LOCK;
                    cnt_d    = '0;
                    loss_inc = 1'b1;
                end
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs decoded from the next state
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            retry_cnt <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pll_rst <= (state_d == RESET_PLL);
            sys_rst <= (state_d != RUN);
            ready   <= (state_d == RUN);
            if (retry_inc && (retry_cnt != 8'hFF)) begin
                retry_cnt <= retry_cnt + 8'd1;
            end
        end
    end

`ifdef PLL_SUP_LOSS_CNT_EN
    logic [15:0] loss_q;

    assign loss_cnt = loss_q;

    // Saturating count of lock losses while running
    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_q <= 16'd0;
        end else if (loss_inc && (loss_q != 16'hFFFF)) begin
            loss_q <= loss_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_soc_pll_lock_supervisor.sv
// tb_soc_pll_lock_supervisor: table-driven vectors plus corner sequences.
// Loss-counter checks are built when PLL_SUP_LOSS_CNT_EN is defined.
module tb_soc_pll_lock_supervisor;

    localparam int RST_HOLD     = 4;
    localparam int LOCK_TIMEOUT = 20;
    localparam int STABLE_CNT   = 8;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [1:0] state;
    logic [7:0] retry_cnt;
`ifdef PLL_SUP_LOSS_CNT_EN
    logic [15:0] loss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    soc_pll_lock_supervisor #(
        .RST_HOLD    (RST_HOLD),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .STABLE_CNT  (STABLE_CNT),
        .CW          (16)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .state     (state),
`ifdef PLL_SUP_LOSS_CNT_EN
        .loss_cnt  (loss_cnt),
`endif
        .retry_cnt (retry_cnt)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        string      name;
        logic       rst;
        logic       lock;
        int         n;
        logic       e_pll;
        logic       e_sys;
        logic       e_rdy;
        logic [1:0] e_st;
        logic [7:0] e_rc;
    } vec_t;

    vec_t vecs[16];

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    function automatic logic [15:0] outs();
        return {3'b000, pll_rst, sys_rst, ready, state, retry_cnt};
    endfunction

    function automatic logic [15:0] ex(input logic p, input logic s,
                                       input logic r, input logic [1:0] st,
                                       input logic [7:0] rc);
        return {3'b000, p, s, r, st, rc};
    endfunction

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{"rst_hold",     1, 1, 2,    1, 1, 0, 0, 0};
        vecs[1]  = '{"pll_rst_c3",   0, 1, 3,    1, 1, 0, 0, 0};
        vecs[2]  = '{"wait_c4",      0, 1, 1,    0, 1, 0, 1, 0};
        vecs[3]  = '{"stable_c5",    0, 1, 1,    0, 1, 0, 2, 0};
        vecs[4]  = '{"stable_c12",   0, 1, 7,    0, 1, 0, 2, 0};
        vecs[5]  = '{"run_c13",      0, 1, 1,    0, 0, 1, 3, 0};
        vecs[6]  = '{"rst_in_run",   1, 0, 1,    1, 1, 0, 0, 0};
        vecs[7]  = '{"nolock_wait",  0, 0, 4,    0, 1, 0, 1, 0};
        vecs[8]  = '{"wait_last",    0, 0, 19,   0, 1, 0, 1, 0};
        vecs[9]  = '{"timeout1",     0, 0, 1,    1, 1, 0, 0, 1};
        vecs[10] = '{"timeout2",     0, 0, 24,   1, 1, 0, 0, 2};
        vecs[11] = '{"timeout3",     0, 0, 24,   1, 1, 0, 0, 3};
        vecs[12] = '{"wait_after3",  0, 0, 4,    0, 1, 0, 1, 3};
        vecs[13] = '{"rst_in_wait",  1, 0, 1,    1, 1, 0, 0, 0};
        vecs[14] = '{"retry_sat",    0, 0, 6144, 1, 1, 0, 0, 255};
        vecs[15] = '{"rst_clr_sat",  1, 0, 1,    1, 1, 0, 0, 0};

        rst = 1'b1;
        pll_locked = 1'b0;

        for (int i = 0; i < 16; i++) begin
            rst = vecs[i].rst;
            pll_locked = vecs[i].lock;
            step(vecs[i].n);
            chk(vecs[i].name, outs(),
                ex(vecs[i].e_pll, vecs[i].e_sys, vecs[i].e_rdy,
                   vecs[i].e_st, vecs[i].e_rc));
        end

        pll_locked = 1'b1;
        step(1);
        rst = 1'b0;
        step(8);
        pll_locked = 1'b0;
        step(2);
        chk("glitch_stable", outs(), ex(0, 1, 0, 2, 0));
        pll_locked = 1'b1;
        step(1);
        chk("glitch_wait", outs(), ex(0, 1, 0, 1, 0));
        step(1);
        chk("glitch_wait2", outs(), ex(0, 1, 0, 1, 0));
        step(8);
        chk("relock_stable", outs(), ex(0, 1, 0, 2, 0));
        step(1);
        chk("relock_run", outs(), ex(0, 0, 1, 3, 0));

        pll_locked = 1'b0;
        step(2);
        chk("loss_lat2", outs(), ex(0, 0, 1, 3, 0));
        step(1);
        chk("loss_lat3", outs(), ex(0, 1, 0, 1, 0));
        pll_locked = 1'b1;
        step(10);
        chk("loss_stable", outs(), ex(0, 1, 0, 2, 0));
        step(1);
        chk("loss_run", outs(), ex(0, 0, 1, 3, 0));

`ifdef PLL_SUP_LOSS_CNT_EN
        for (int k = 0; k < 2; k++) begin
            pll_locked = 1'b0;
            step(3);
            pll_locked = 1'b1;
            step(11);
        end
        chk("loss_cnt3", loss_cnt, 16'd3);
        force dut.loss_q = 16'hFFFF;
        step(1);
        release dut.loss_q;
        pll_locked = 1'b0;
        step(3);
        pll_locked = 1'b1;
        step(11);
        chk("loss_cnt_sat", loss_cnt, 16'hFFFF);
`endif

        rst = 1'b1;
        pll_locked = 1'b0;
        step(1);
        rst = 1'b0;
        step(21);
        pll_locked = 1'b1;
        step(2);
        chk("tl_wait_last", outs(), ex(0, 1, 0, 1, 0));
        step(1);
        chk("tl_lock_wins", outs(), ex(0, 1, 0, 2, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
